uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receive front-end for the memory-mapped peripheral block of the pipeline CPU.
- Deserialises 8N1 frames from the board RX pin and buffers received bytes in a small show-ahead FIFO.
- The peripheral register file pops bytes on CPU loads and raises an interrupt while data is pending.
- Sits directly upstream of the peripheral read-data path and its interrupt output.

Parameters:
- BAUD_DIV, 5208, clock cycles per bit (50 MHz / 9600); must be ≥ 4 and even.
- DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- rx  input  1  serial line; idle high; asynchronous to clk
- rd_en  input  1  pop head byte; one pop per cycle asserted
- clr_err  input  1  clear sticky error flags
- rx_data  output  8  FIFO head byte, show-ahead; undefined-but-stable when empty
- rx_valid  output  1  FIFO not empty
- rx_full  output  1  FIFO full
- overrun  output  1  sticky: a frame was dropped because the FIFO was full
- frame_err  output  1  sticky: a stop bit sampled low
- irq  output  1  equals rx_valid

Behaviour:
- Reset (reset=0, async):
  - FSM to IDLE; counters 0; FIFO empty.
  - rx_data=0, rx_valid=0, rx_full=0, overrun=0, frame_err=0, irq=0.
  - Both rx synchroniser flops set to 1.
- Synchroniser: rx passes through 2 flops before the FSM; rx_s is the second flop.
- FSM states IDLE, START, DATA, STOP; baud counter cnt and bit index bidx[2:0].
- IDLE: if rx_s==0, go to START with cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==BAUD_DIV/2-1, sample rx_s:
    - 0 → DATA, cnt=0, bidx=0.
    - 1 → glitch, return to IDLE with no flag.
- DATA:
  - At cnt==BAUD_DIV-1, shift rx_s into bit bidx (LSB first) and reset cnt.
  - After bidx==7, go to STOP; otherwise bidx+1.
- STOP: at cnt==BAUD_DIV-1, sample rx_s, then go to IDLE in the same cycle:
  - 1 and FIFO not full → push byte.
  - 1 and FIFO full → byte discarded, overrun←1.
  - 0 → byte discarded, frame_err←1; FSM then waits in IDLE for rx_s==0.
- Latency: a byte pushed in cycle N is visible on rx_data/rx_valid in cycle N+1.
- FIFO:
  - Circular buffer, 2^DEPTH_LOG2 entries; wr/rd pointers with DEPTH_LOG2 bits that wrap naturally; count is DEPTH_LOG2+1 bits.
  - rx_full = (count==2^DEPTH_LOG2).
  - rd_en while empty: ignored, no pointer change.
  - Simultaneous push and pop while full: pop occurs and the push is accepted; count unchanged, no overrun.
  - Simultaneous push and pop while empty: push is accepted, the pop is ignored, count becomes 1.
- Sticky flags:
  - Set as above; cleared only by clr_err or reset.
  - If clr_err and a set event occur in the same cycle, set wins.
- Mid-frame reset aborts the frame immediately with no push and no flag.
- Mid-frame rd_en is independent of the FSM.

Test Plan:
- BAUD_DIV=16. Drive frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0 LSB first, stop 1), 16 cycles per bit → rx_valid=1, rx_data=8'h55, irq=1; pulse rd_en one cycle → rx_valid=0 next cycle.
- Glitch: rx low for 4 cycles, then high → FSM returns to IDLE; no push; frame_err=0.
- Bad stop: frame 0xA3 with stop bit 0 → no push; frame_err=1; pulse clr_err → frame_err=0.
- Fill/overrun: send 0x01..0x05 with no reads → rx_full=1 after the 4th byte; 5th byte dropped, overrun=1; four pops return 0x01, 0x02, 0x03, 0x04, then rx_valid=0.
- Full with coincident pop: hold 4 bytes and assert rd_en in exactly the 5th byte's push cycle → count stays 4, overrun=0, order 0x02, 0x03, 0x04, 0x05.
- Reset mid-frame: assert reset during bit 3 of frame 0xFF → all outputs 0 immediately; after release, frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- 8N1 UART receiver feeding a small show-ahead FIFO.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   rd_en      pop the head byte (ignored while empty)
//   clr_err    clear sticky overrun / frame_err
//   rx_data    FIFO head byte (show-ahead)
//   rx_valid   FIFO not empty
//   rx_full    FIFO full
//   overrun    sticky: good frame dropped because FIFO was full
//   frame_err  sticky: stop bit sampled low
//   irq        mirrors rx_valid
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 5208,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err,
  output logic       irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0]      HALF_M1  = CNT_W'(BAUD_DIV/2 - 1);
  localparam logic [CNT_W-1:0]      FULL_M1  = CNT_W'(BAUD_DIV - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- synchroniser ----------------
  logic r_rx_meta, r_rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // ---------------- receive FSM ----------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bidx;
  logic [7:0]       r_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) r_state <= S_START;
        end
        S_START: begin
          // Re-check the line at mid start bit; a high here was a glitch.
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= S_DATA;
              r_bidx  <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt           <= '0;
            r_shift[r_bidx] <= r_rx_s;
            if (r_bidx == 3'd7) r_state <= S_STOP;
            else                r_bidx  <= r_bidx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stop-bit decision is combinational so the byte lands in the FIFO on the
  // same edge the FSM returns to IDLE.
  logic w_stop_smp, w_push_req, w_ferr_set;
  assign w_stop_smp = (r_state == S_STOP) && (r_cnt == FULL_M1);
  assign w_push_req = w_stop_smp &&  r_rx_s;
  assign w_ferr_set = w_stop_smp && !r_rx_s;

  // ---------------- FIFO ----------------
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overrun, r_frame_err;

  logic w_full, w_pop, w_push, w_ovr_set;
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = rd_en && (r_count != '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_ovr_set = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags: a set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
      if (w_ferr_set)   r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
    end
  end

  assign rx_data   = r_mem[r_rd_ptr];
  assign rx_valid  = (r_count != '0);
  assign rx_full   = w_full;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign irq       = rx_valid;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (BAUD_DIV=16, depth 4).
// Reference model: a byte queue plus two sticky flags, updated per whole
// frame / per pop from the protocol rules.
module tb_uart_rx_fifo;
  localparam int BD    = 16;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * BD;
  // Edge index (from the frame's first cycle) at which the stop bit is judged:
  // 2 sync flops + 1 IDLE detect + BD/2 mid-start + 9 bit periods.
  localparam int PUSH_C = 3 + BD/2 + 9*BD - 1;

  logic       clk = 1'b0, reset, rx, rd_en, clr_err;
  logic [7:0] rx_data;
  logic       rx_valid, rx_full, overrun, frame_err, irq;

  uart_rx_fifo #(.BAUD_DIV(BD), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .overrun(overrun), .frame_err(frame_err), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] mq[$];
  bit m_ovr = 0, m_ferr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, rx_valid, mq.size() != 0);
    chk({tag, "_full"},  rx_full,  mq.size() == DEPTH);
    chk({tag, "_irq"},   irq,      mq.size() != 0);
    chk({tag, "_ovr"},   overrun,  m_ovr);
    chk({tag, "_ferr"},  frame_err, m_ferr);
    if (mq.size() != 0) chk({tag, "_data"}, rx_data, mq[0]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"},  rx_data, 0);
    chk({tag, "_valid"}, rx_valid, 0);
    chk({tag, "_full"},  rx_full, 0);
    chk({tag, "_ovr"},   overrun, 0);
    chk({tag, "_ferr"},  frame_err, 0);
    chk({tag, "_irq"},   irq, 0);
  endtask

  // Drive one 8N1 frame; optionally pop / clear / reset at a given cycle.
  task automatic send_frame(input logic [7:0] d, input bit stopb,
                            input int pop_c, input int clr_c, input int rst_c);
    logic [9:0] bits;
    bit aborted;
    bits = {stopb, d, 1'b0};
    aborted = 0;
    for (int c = 0; c < FLEN; c++) begin
      rx      = bits[c / BD];
      rd_en   = (c == pop_c);
      clr_err = (c == clr_c);
      if (c == pop_c && mq.size() != 0) begin
        chk("pop_in_frame", rx_data, mq[0]);
        void'(mq.pop_front());
      end
      if (c == clr_c) begin m_ovr = 0; m_ferr = 0; end
      if (c == rst_c) begin
        reset = 1'b0;
        #1;
        check_zero("midrst");
        mq.delete(); m_ovr = 0; m_ferr = 0; aborted = 1;
      end
      if (c == rst_c + 2) reset = 1'b1;
      @(posedge clk); #1;
    end
    rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    if (!aborted) begin
      if (!stopb)                   m_ferr = 1;
      else if (mq.size() < DEPTH)   mq.push_back(d);
      else                          m_ovr = 1;
    end
  endtask

  // Idle line; pops each cycle with probability 1/pop_div (0 = never).
  task automatic idle(input int n, input int pop_div, input bit allow_clr);
    for (int c = 0; c < n; c++) begin
      rx      = 1'b1;
      rd_en   = (pop_div != 0) && ($urandom_range(0, pop_div - 1) == 0);
      clr_err = allow_clr && ($urandom_range(0, 99) == 0);
      if (rd_en && mq.size() != 0) begin
        chk("idle_pop", rx_data, mq[0]);
        void'(mq.pop_front());
      end
      if (!rd_en) chk("idle_valid", rx_valid, mq.size() != 0);
      if (clr_err) begin m_ovr = 0; m_ferr = 0; end
      @(posedge clk); #1;
    end
    rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic pop_exp(input string tag, input logic [7:0] exp);
    chk(tag, rx_data, exp);
    chk({tag, "_v"}, rx_valid, 1);
    if (mq.size() != 0) void'(mq.pop_front());
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rx = 1'b1; reset = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    idle(5, 0, 0);

    // basic frame
    send_frame(8'h55, 1, -1, -1, -100);
    idle(4, 0, 0);
    check_state("f55");
    chk("f55_byte", rx_data, 8'h55);
    pop_exp("f55_pop", 8'h55);
    chk("f55_empty", rx_valid, 0);

    // glitch on the line: short low pulse
    rx = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rx = 1'b1;
    idle(40, 0, 0);
    check_state("glitch");

    // bad stop bit, then clear
    send_frame(8'hA3, 0, -1, -1, -100);
    idle(20, 0, 0);
    check_state("badstop");
    chk("badstop_ferr", frame_err, 1);
    clr_err = 1'b1; m_ferr = 0; m_ovr = 0;
    @(posedge clk); #1; clr_err = 1'b0;
    check_state("clr");

    // fill and overrun
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1, -1, -1, -100);
      idle(20, 0, 0);
      check_state($sformatf("fill%0d", i));
      if (i == 4) chk("fill_full", rx_full, 1);
    end
    chk("ovr_set", overrun, 1);
    for (int i = 1; i <= 4; i++) pop_exp($sformatf("drain%0d", i), 8'(i));
    chk("drain_empty", rx_valid, 0);
    clr_err = 1'b1; m_ovr = 0;
    @(posedge clk); #1; clr_err = 1'b0;

    // full FIFO with pop in the push cycle
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1, -1, -1, -100);
      idle(20, 0, 0);
    end
    send_frame(8'h05, 1, PUSH_C, -1, -100);
    idle(4, 0, 0);
    check_state("coinc");
    chk("coinc_full", rx_full, 1);
    chk("coinc_ovr", overrun, 0);
    for (int i = 2; i <= 5; i++) pop_exp($sformatf("coinc_pop%0d", i), 8'(i));
    chk("coinc_empty", rx_valid, 0);

    // clear coinciding with a frame error: set wins
    send_frame(8'h5A, 0, -1, PUSH_C, -100);
    idle(20, 0, 0);
    chk("setwins_ferr", frame_err, 1);
    check_state("setwins");
    clr_err = 1'b1; m_ferr = 0; m_ovr = 0;
    @(posedge clk); #1; clr_err = 1'b0;

    // reset during bit 3, then a clean frame
    send_frame(8'h00, 1, -1, -1, -100);
    send_frame(8'hFF, 1, -1, -1, 4*BD + BD/2);
    idle(20, 0, 0);
    check_state("postrst");
    send_frame(8'h3C, 1, -1, -1, -100);
    idle(10, 0, 0);
    check_state("f3c");
    chk("f3c_byte", rx_data, 8'h3C);
    while (mq.size() != 0) pop_exp("f3c_drain", mq[0]);

    // randomized traffic
    for (int f = 0; f < 60; f++) begin
      logic [7:0] d;
      bit sb;
      int pc;
      d  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      pc = (mq.size() == DEPTH && $urandom_range(0, 1) == 1) ? PUSH_C : -1;
      send_frame(d, sb, pc, -1, -100);
      idle(3, 0, 0);
      check_state("rnd");
      idle($urandom_range(20, 60), ($urandom_range(0, 2) == 0) ? 3 : 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
